bist_log_reader: RTL and testbench
==================================

Name: bist_log_reader

Overview:
- Drains the error records produced by the march-C result stage and transmits them off-chip on a single serial line, so failing cells can be read out after or during a BIST run.
- Accepts one 26-bit record per rec_valid pulse into a small FIFO.
- Each record is serialised as one UART-style frame: start bit, 26 data bits LSB first, stop bit.
- After the test finishes and the FIFO is empty, sends one end-of-test trailer frame.

Parameters:
- RW, 26, record width: {cs[1:0], a[16:0], cycle[2:0], ec[3:0]}.
- DEPTH, 16, FIFO entries; must be a power of two.
- AW, 4, log2(DEPTH).
- CLKS_PER_BIT, 4, clock cycles per serial bit (must be ≥2).
- TRAILER, 26'h3FFFFFF, end-of-test record (cs=2'b11 never occurs in a real record).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- rec_valid  input  1  one-cycle strobe: rec_data holds a new error record.
- rec_data  input  RW  error record from result stage.
- test_done  input  1  level; BIST sequence has finished.
- tx  output  1  serial output, idle high.
- busy  output  1  high while a frame is on tx or FIFO is non-empty.
- overflow  output  1  sticky; a record was dropped because FIFO was full.
- rec_cnt  output  16  records accepted into FIFO, saturating at 16'hFFFF.
- drop_cnt  output  8  records dropped, saturating at 8'hFF.
- log_done  output  1  sticky; trailer frame fully transmitted.

Behaviour:
- Reset (async, any time, including mid-frame) sets:
  - tx=1, busy=0, overflow=0, rec_cnt=0, drop_cnt=0, log_done=0.
  - FIFO pointers=0, FIFO count=0, FSM=IDLE, bit counter=0, baud counter=0.
  - The partially sent frame is abandoned, with no stop bit.
- FIFO: count width AW+1.
  - Push when rec_valid && (count<DEPTH).
  - Pop when the FSM loads a record in IDLE.
  - Simultaneous push and pop when full: the pop takes effect and the push is accepted, so count stays DEPTH and nothing is dropped.
  - Push when full with no pop: record dropped, overflow<=1, drop_cnt+1 (saturating); rec_cnt unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states IDLE, START, DATA, STOP, DONE:
  - IDLE: if FIFO non-empty, load the head into shift reg, pop, go to START.
  - IDLE: else if test_done && !log_done, load TRAILER, set trailer flag, go to START.
  - IDLE: otherwise stay, tx=1.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, then shift right; after bit RW-1 go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles.
  - STOP exit: if trailer flag, go to DONE and set log_done=1; else go to IDLE.
  - DONE: tx=1, stay until reset. Records still pushed in DONE are counted and held, never transmitted.
- Frame length = (RW+2)*CLKS_PER_BIT cycles, i.e. 112 with defaults. Back-to-back frames have exactly one IDLE cycle between the stop bit and the next start bit.
- Latency: a record pushed into an empty FIFO with FSM in IDLE at edge N is popped at edge N+1; tx falls after edge N+2.
- Trailer ordering: sent only when the FIFO is empty. Records arriving while test_done is high but before the trailer starts are sent first.
- tx is driven from a register, glitch-free.
- busy = (FSM != IDLE && FSM != DONE) || count != 0.

Test Plan:
- Single record 26'h2ABCDE5 pushed after reset, CLKS_PER_BIT=4 -> tx low for 4 clocks, then bits 1,0,1,0,0,1,1,1,1,0,1,1,0,0,1,1,1,1,0,1,0,1,0,1,0,1 (LSB first), each 4 clocks, then high for 4 clocks. Frame is 112 clocks; rec_cnt=1, busy falls after the stop bit.
- 20 records pushed on consecutive cycles with DEPTH=16 -> first is popped at once, so 17 are accepted. rec_cnt=17, drop_cnt=3, overflow=1. Exactly 17 frames appear, in push order, with 1-cycle gaps.
- Push while full, on the same cycle as an IDLE pop -> no drop; count stays 16, drop_cnt unchanged.
- test_done raised with 2 records queued -> two record frames, then the trailer frame (26 ones). log_done=1 after the trailer stop bit; tx stays 1 afterwards.
- Reset asserted in the middle of DATA bit 10 -> tx=1 and all counters and flags 0 immediately, with no clock edge needed. A new record after release produces a full, correct frame.
- test_done high with an empty FIFO right after reset -> trailer frame starts within 2 clocks; rec_cnt=0, log_done=1 at completion.

Source files
------------

// File: rtl/bist_log_reader.sv
// BIST error-log drain: buffers march-C error records in a FIFO and ships each one
// as a UART-style frame on tx, followed by a single all-ones trailer once the test is done.
module bist_log_reader #(
    parameter int             RW           = 26,
    parameter int             DEPTH        = 16,
    parameter int             AW           = 4,
    parameter int             CLKS_PER_BIT = 4,
    parameter logic [RW-1:0]  TRAILER      = 26'h3FFFFFF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rec_valid,
    input  logic [RW-1:0] rec_data,
    input  logic          test_done,
    output logic          tx,
    output logic          busy,
    output logic          overflow,
    output logic [15:0]   rec_cnt,
    output logic [7:0]    drop_cnt,
    output logic          log_done
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = $clog2(RW);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_DONE} state_t;

    logic [RW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [15:0]   r_rec_cnt;
    logic [7:0]    r_drop_cnt;
    logic          r_overflow;

    state_t        r_state;
    logic [RW-1:0] r_shift;
    logic [BW-1:0] r_baud;
    logic [IW-1:0] r_bit;
    logic          r_trailer;
    logic          r_tx;
    logic          r_log_done;

    logic w_pop, w_full, w_push, w_drop, w_baud_end, w_bit_end;

    // A pop on the same edge frees a slot, so a push into a full FIFO still lands.
    assign w_pop      = (r_state == S_IDLE) && (r_count != '0);
    assign w_full     = (r_count == (AW+1)'(DEPTH));
    assign w_push     = rec_valid && (!w_full || w_pop);
    assign w_drop     = rec_valid && w_full && !w_pop;
    assign w_baud_end = (r_baud == BW'(CLKS_PER_BIT - 1));
    assign w_bit_end  = (r_bit == IW'(RW - 1));

    // NOTE: the record storage has no reset; pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= rec_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_rec_cnt  <= '0;
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
                if (r_rec_cnt != 16'hFFFF) begin
                    r_rec_cnt <= r_rec_cnt + 16'd1;
                end
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (AW+1)'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - (AW+1)'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 8'hFF) begin
                    r_drop_cnt <= r_drop_cnt + 8'd1;
                end
            end
        end
    end

    // tx is registered from the current state, so it lags the state by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_baud     <= '0;
            r_bit      <= '0;
            r_trailer  <= 1'b0;
            r_tx       <= 1'b1;
            r_log_done <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx   <= 1'b1;
                    r_baud <= '0;
                    r_bit  <= '0;
                    if (r_count != '0) begin
                        r_shift <= r_mem[r_rd_ptr];
                        r_state <= S_START;
                    end else if (test_done && !r_log_done) begin
                        r_shift   <= TRAILER;
                        r_trailer <= 1'b1;
                        r_state   <= S_START;
                    end
                end
                S_START: begin
                    r_tx <= 1'b0;
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_state <= S_DATA;
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                S_DATA: begin
                    r_tx <= r_shift[0];
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_shift <= r_shift >> 1;
                        if (w_bit_end) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit <= r_bit + IW'(1);
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                S_STOP: begin
                    r_tx <= 1'b1;
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (r_trailer) begin
                            r_log_done <= 1'b1;
                            r_state    <= S_DONE;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + BW'(1);
                    end
                end
                S_DONE: begin
                    r_tx <= 1'b1;
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign tx       = r_tx;
    assign busy     = ((r_state != S_IDLE) && (r_state != S_DONE)) || (r_count != '0);
    assign overflow = r_overflow;
    assign rec_cnt  = r_rec_cnt;
    assign drop_cnt = r_drop_cnt;
    assign log_done = r_log_done;

endmodule

// File: tb/tb_bist_log_reader.sv
// Bench for bist_log_reader: a serial receiver decodes tx frames and compares each one
// against a scoreboard queue filled as records are driven.
module tb_bist_log_reader;

    localparam int          RW      = 26;
    localparam logic [25:0] TRAILER = 26'h3FFFFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rec_valid = 1'b0;
    logic [25:0] rec_data = '0;
    logic        test_done = 1'b0;
    logic        tx, busy, overflow, log_done;
    logic [15:0] rec_cnt;
    logic [7:0]  drop_cnt;

    bist_log_reader dut (
        .clk       (clk),
        .reset     (reset),
        .rec_valid (rec_valid),
        .rec_data  (rec_data),
        .test_done (test_done),
        .tx        (tx),
        .busy      (busy),
        .overflow  (overflow),
        .rec_cnt   (rec_cnt),
        .drop_cnt  (drop_cnt),
        .log_done  (log_done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard and frame receiver
    logic [25:0] exp_q[$];
    logic [25:0] mon_data;
    logic [25:0] exp_v;
    bit          mon_active = 1'b0;
    bit          have_last  = 1'b0;
    bit          expect_b2b = 1'b0;
    int          mon_cnt    = 0;
    int          cyc        = 0;
    int          last_start = 0;
    int          frames     = 0;

    // Frame indices count negedges from the first start-bit sample: data bit i at 4+4i, stop at 108.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            mon_active = 1'b0;
            have_last  = 1'b0;
        end else if (!mon_active) begin
            if (tx === 1'b0) begin
                mon_active = 1'b1;
                mon_cnt    = 0;
                if (expect_b2b && have_last) begin
                    check("frame_gap", cyc - last_start, 113);
                end
                last_start = cyc;
                have_last  = 1'b1;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt == 112) begin
                mon_active = 1'b0;
            end else if (mon_cnt == 2) begin
                check("start_bit", tx, 0);
            end else if (mon_cnt >= 4 && mon_cnt < 108 && (mon_cnt % 4) == 0) begin
                mon_data[(mon_cnt - 4) / 4] = tx;
            end else if (mon_cnt == 108) begin
                check("stop_bit", tx, 1);
                frames++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_frame: got %0h expected no frame at %0t", mon_data, $time);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("frame_data", mon_data, exp_v);
                end
            end
        end
    end

    task automatic push(input logic [25:0] d, input bit accepted);
        rec_valid = 1'b1;
        rec_data  = d;
        if (accepted) exp_q.push_back(d);
        @(negedge clk);
        rec_valid = 1'b0;
    endtask

    task automatic drain(input int max_cyc);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mon_active || busy) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check("drain_in_time", (n < max_cyc), 1);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        rec_valid = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
        check("rst_rec_cnt", rec_cnt, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_log_done", log_done, 0);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [25:0] data;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t vecs[4];
    int   frames_before;
    bit   found;
    int   k;

    initial begin
        vecs[0] = '{data: 26'h0000000, exp_cnt: 16'd2};
        vecs[1] = '{data: 26'h2FFFFFF, exp_cnt: 16'd3};
        vecs[2] = '{data: 26'h1555555, exp_cnt: 16'd4};
        vecs[3] = '{data: 26'h0AAAAAA, exp_cnt: 16'd5};

        @(negedge clk);
        do_reset();

        // Single record: pop one edge after the push, tx falls after the next edge.
        rec_valid = 1'b1;
        rec_data  = 26'h2ABCDE5;
        exp_q.push_back(26'h2ABCDE5);
        @(negedge clk);
        rec_valid = 1'b0;
        check("lat_n_tx", tx, 1);
        check("lat_rec_cnt", rec_cnt, 1);
        @(negedge clk);
        check("lat_n1_tx", tx, 1);
        @(negedge clk);
        check("lat_n2_tx", tx, 0);
        check("lat_busy", busy, 1);
        drain(300);
        check("single_rec_cnt", rec_cnt, 1);
        check("single_busy", busy, 0);

        for (int i = 0; i < 4; i++) begin
            push(vecs[i].data, 1'b1);
            drain(300);
            check("tbl_rec_cnt", rec_cnt, vecs[i].exp_cnt);
            check("tbl_busy", busy, 0);
            check("tbl_tx_idle", tx, 1);
        end

        // Burst of 20: 17 accepted, 3 dropped; then a push lands on a full-FIFO pop cycle.
        do_reset();
        expect_b2b    = 1'b1;
        frames_before = frames;
        for (int i = 0; i < 20; i++) begin
            push(26'h0100000 + 26'(i), (i < 17));
        end
        check("burst_rec_cnt", rec_cnt, 17);
        check("burst_drop_cnt", drop_cnt, 3);
        check("burst_overflow", overflow, 1);
        found = 1'b0;
        for (int j = 0; j < 200; j++) begin
            @(negedge clk);
            #1;
            if (mon_active && mon_cnt == 111) begin
                found = 1'b1;
                break;
            end
        end
        check("full_pop_cycle_found", found, 1);
        rec_valid = 1'b1;
        rec_data  = 26'h0C0FFEE;
        exp_q.push_back(26'h0C0FFEE);
        @(negedge clk);
        rec_valid = 1'b0;
        check("full_pop_rec_cnt", rec_cnt, 18);
        check("full_pop_drop_cnt", drop_cnt, 3);
        check("full_pop_busy", busy, 1);
        drain(18 * 115 + 200);
        expect_b2b = 1'b0;
        check("burst_frames", frames - frames_before, 18);
        check("burst_overflow_sticky", overflow, 1);

        // Two records queued, then test_done: both go out before the trailer.
        do_reset();
        push(26'h0012345, 1'b1);
        push(26'h1234567, 1'b1);
        test_done = 1'b1;
        exp_q.push_back(TRAILER);
        drain(600);
        check("td_log_done", log_done, 1);
        check("td_rec_cnt", rec_cnt, 2);
        check("td_tx", tx, 1);
        push(26'h0123456, 1'b0);
        @(negedge clk);
        check("done_rec_cnt", rec_cnt, 3);
        check("done_busy", busy, 1);
        repeat (150) @(negedge clk);
        check("done_tx_idle", tx, 1);
        check("done_log_done", log_done, 1);
        test_done = 1'b0;

        // Asynchronous reset during data bit 10 of an all-zero record.
        do_reset();
        push(26'h0000000, 1'b1);
        found = 1'b0;
        for (int j = 0; j < 200; j++) begin
            @(negedge clk);
            #1;
            if (mon_active && mon_cnt == 46) begin
                found = 1'b1;
                break;
            end
        end
        check("bit10_found", found, 1);
        check("pre_reset_tx", tx, 0);
        #1;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check("async_rst_tx", tx, 1);
        check("async_rst_busy", busy, 0);
        check("async_rst_rec_cnt", rec_cnt, 0);
        check("async_rst_drop_cnt", drop_cnt, 0);
        check("async_rst_overflow", overflow, 0);
        check("async_rst_log_done", log_done, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        push(26'h2ABCDE5, 1'b1);
        drain(300);
        check("post_rst_rec_cnt", rec_cnt, 1);

        // test_done already high when reset releases with an empty FIFO.
        reset     = 1'b1;
        test_done = 1'b1;
        exp_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        exp_q.push_back(TRAILER);
        k = 0;
        while (tx !== 1'b0 && k < 4) begin
            @(negedge clk);
            k++;
        end
        check("trailer_start_within_2", (k <= 2), 1);
        drain(300);
        check("trailer_log_done", log_done, 1);
        check("trailer_rec_cnt", rec_cnt, 0);
        check("trailer_tx", tx, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
